// File: rtl/fetch_decoder.sv
// Instruction fetch/decode stage: fetches one word per instruction at pc, decodes
// control class, immediate, jump-register target and branch condition, and paces the PC.
module fetch_decoder #(
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  output logic [4:0]         rf_raddr,
  input  logic [31:0]        rf_rdata,
  input  logic               zero_flag,
  output logic               halt,
  output logic [2:0]         opcode,
  output logic [15:0]        addr,
  output logic [31:0]        jreg,
  output logic               condition_bit,
  output logic               stopped,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;

  localparam logic [2:0] CLS_SEQ = 3'b000;
  localparam logic [2:0] CLS_J   = 3'b100;
  localparam logic [2:0] CLS_JR  = 3'b101;
  localparam logic [2:0] CLS_BEQ = 3'b110;
  localparam logic [2:0] CLS_BNE = 3'b111;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t             state;
  logic [31:0]        ir;
  logic [COUNT_W-1:0] count;

  logic [5:0] ir_op;
  logic [5:0] ir_funct;
  logic       ir_is_halt;
  logic       in_exec;
  logic       unused_rt;

  assign ir_op      = ir[31:26];
  assign ir_funct   = ir[5:0];
  assign ir_is_halt = (ir_op == HALT_OP);
  assign in_exec    = (state == ST_EXEC);
  assign unused_rt  = ^ir[20:16];

  // Sequencer: IR and the retired count are captured on the accepting fetch edge,
  // so the count already includes the instruction while it sits in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
      ir    <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_RESET: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            count <= count + COUNT_W'(1);
            state <= ST_EXEC;
          end
        end
        ST_EXEC:  state <= ir_is_halt ? ST_STOP : ST_FETCH;
        ST_STOP:  state <= ST_STOP;
        default:  state <= ST_RESET;
      endcase
    end
  end

  // Fetch-side outputs follow state directly so reset clears them without a clock edge.
  always_comb begin
    imem_req    = (state == ST_FETCH);
    imem_addr   = pc;
    rf_raddr    = ir[25:21];
    halt        = !(in_exec && !ir_is_halt);
    stopped     = (state == ST_STOP) || (in_exec && ir_is_halt);
    instr_count = count;
  end

  // Decode; register-file data and zero flag pass through combinationally in EXEC.
  always_comb begin
    opcode        = CLS_SEQ;
    addr          = '0;
    jreg          = '0;
    condition_bit = 1'b0;
    if (in_exec) begin
      addr = ir[15:0];
      if (ir_is_halt) begin
        opcode = CLS_SEQ;
      end else begin
        case (ir_op)
          OP_J:       opcode = CLS_J;
          OP_BEQ: begin
            opcode        = CLS_BEQ;
            condition_bit = zero_flag;
          end
          OP_BNE: begin
            opcode        = CLS_BNE;
            condition_bit = !zero_flag;
          end
          OP_SPECIAL: begin
            if (ir_funct == FN_JR) begin
              opcode = CLS_JR;
              jreg   = rf_rdata;
            end
          end
          default:    opcode = CLS_SEQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_decoder.sv
// Directed bench for fetch_decoder with hand-computed expectations.
module tb_fetch_decoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        zero_flag;
  logic        halt;
  logic [2:0]  opcode;
  logic [15:0] addr;
  logic [31:0] jreg;
  logic        condition_bit;
  logic        stopped;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_decoder #(.HALT_OP(6'h3F), .COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .zero_flag(zero_flag), .halt(halt), .opcode(opcode), .addr(addr),
    .jreg(jreg), .condition_bit(condition_bit), .stopped(stopped),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one fetch with the given number of wait cycles; returns in the EXEC cycle.
  task automatic fetch(input logic [31:0] instr, input int waits, input string tag);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      #1;
      chk({tag, "_wait_req"}, 64'(imem_req), 64'd1);
      chk({tag, "_wait_addr"}, 64'(imem_addr), 64'(pc));
      chk({tag, "_wait_halt"}, 64'(halt), 64'd1);
      step();
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    #1;
    chk({tag, "_fetch_req"}, 64'(imem_req), 64'd1);
    chk({tag, "_fetch_addr"}, 64'(imem_addr), 64'(pc));
    chk({tag, "_fetch_halt"}, 64'(halt), 64'd1);
    step();
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Leave EXEC; the PC controller advances at this edge.
  task automatic retire();
    step();
    pc = pc + 32'd4;
  endtask

  initial begin
    rst_n = 1'b0; pc = 32'h0000_0100; imem_rdata = '0; imem_valid = 1'b0;
    rf_rdata = '0; zero_flag = 1'b0;
    step(); step();
    chk("rst_halt", 64'(halt), 64'd1);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_opcode", 64'(opcode), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_jreg", 64'(jreg), 64'd0);
    chk("rst_cond", 64'(condition_bit), 64'd0);
    chk("rst_stopped", 64'(stopped), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_state_req", 64'(imem_req), 64'd0);
    step();

    // Three sequential NOPs, zero-wait memory
    for (int k = 0; k < 3; k++) begin
      fetch(32'h0000_0000, 0, "seq");
      #1;
      chk("seq_exec_halt", 64'(halt), 64'd0);
      chk("seq_exec_opcode", 64'(opcode), 64'd0);
      chk("seq_exec_req", 64'(imem_req), 64'd0);
      chk("seq_exec_count", 64'(instr_count), 64'(k + 1));
      retire();
    end
    chk("seq_count3", 64'(instr_count), 64'd3);

    // J imm 0x0040 with three wait cycles
    fetch(32'h0800_0040, 3, "j");
    #1;
    chk("j_opcode", 64'(opcode), 64'h4);
    chk("j_addr", 64'(addr), 64'h40);
    chk("j_halt", 64'(halt), 64'd0);
    retire();
    #1;
    chk("j_after_halt", 64'(halt), 64'd1);
    chk("j_after_opcode", 64'(opcode), 64'd0);
    chk("j_after_addr", 64'(addr), 64'd0);

    // JR rs=5
    fetch(32'h00A0_0008, 0, "jr");
    rf_rdata = 32'h0000_1234;
    #1;
    chk("jr_raddr", 64'(rf_raddr), 64'd5);
    chk("jr_opcode", 64'(opcode), 64'h5);
    chk("jr_jreg", 64'(jreg), 64'h1234);
    retire();

    // BEQ taken, BNE not taken, BNE taken
    fetch(32'h1000_0010, 0, "beq");
    zero_flag = 1'b1;
    #1;
    chk("beq_opcode", 64'(opcode), 64'h6);
    chk("beq_cond", 64'(condition_bit), 64'd1);
    chk("beq_addr", 64'(addr), 64'h10);
    retire();
    fetch(32'h1400_0020, 0, "bne1");
    zero_flag = 1'b1;
    #1;
    chk("bne_z1_opcode", 64'(opcode), 64'h7);
    chk("bne_z1_cond", 64'(condition_bit), 64'd0);
    retire();
    fetch(32'h1400_0020, 0, "bne0");
    zero_flag = 1'b0;
    #1;
    chk("bne_z0_cond", 64'(condition_bit), 64'd1);
    retire();

    // op 0 with funct other than JR is sequential
    fetch(32'h00A0_0020, 0, "add");
    #1;
    chk("add_opcode", 64'(opcode), 64'd0);
    chk("add_jreg", 64'(jreg), 64'd0);
    chk("add_count", 64'(instr_count), 64'd9);
    retire();

    // HALT
    fetch(32'hFC00_0000, 0, "halt");
    #1;
    chk("halt_exec_halt", 64'(halt), 64'd1);
    chk("halt_exec_stopped", 64'(stopped), 64'd1);
    chk("halt_exec_count", 64'(instr_count), 64'd10);
    chk("halt_exec_opcode", 64'(opcode), 64'd0);
    step();
    for (int i = 0; i < 20; i++) begin
      imem_valid = 1'(i % 2);
      imem_rdata = 32'h0800_0040;
      #1;
      chk("stop_req", 64'(imem_req), 64'd0);
      chk("stop_halt", 64'(halt), 64'd1);
      chk("stop_stopped", 64'(stopped), 64'd1);
      step();
    end
    chk("stop_count", 64'(instr_count), 64'd10);

    // Reset out of STOP, stale valid during the RESET cycle
    #3;
    rst_n = 1'b0;
    pc = 32'h0000_0000;
    #1;
    chk("rst2_stopped", 64'(stopped), 64'd0);
    chk("rst2_count", 64'(instr_count), 64'd0);
    chk("rst2_halt", 64'(halt), 64'd1);
    step();
    rst_n = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h0800_0040;
    #1;
    chk("rst2_reset_req", 64'(imem_req), 64'd0);
    step();
    imem_valid = 1'b0;
    #1;
    chk("rst2_fetch_req", 64'(imem_req), 64'd1);
    chk("rst2_fetch_addr", 64'(imem_addr), 64'd0);
    chk("rst2_fetch_opcode", 64'(opcode), 64'd0);
    step();
    chk("rst2_stale_req", 64'(imem_req), 64'd1);
    chk("rst2_stale_halt", 64'(halt), 64'd1);

    // One instruction, then reset in the middle of the next FETCH
    fetch(32'h0000_0000, 0, "post");
    #1;
    chk("post_count", 64'(instr_count), 64'd1);
    retire();
    #1;
    chk("mid_req_before", 64'(imem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_req", 64'(imem_req), 64'd0);
    chk("mid_halt", 64'(halt), 64'd1);
    chk("mid_count", 64'(instr_count), 64'd0);
    chk("mid_stopped", 64'(stopped), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
